// File: rtl/mul_tree_feeder_pkg.sv
// -----------------------------------------------------------------------------
// mul_tree_feeder_pkg
// Shared types and helpers for the FP32 multiply-tree feeder.
//  - mode_e        : arity mode encodings (2/3/4/6-input nodes)
//  - ONE_FP        : FP32 1.0, the neutral padding value for unused slots
//  - LATENCY_DFLT  : tree latency from strobe to final product
//  - batch_len()   : number of real words in a full batch for a mode
//  - slot_of()     : operand-bus word slot of the k-th accepted word
//  - nodes_of()    : count of tree nodes that hold at least one real child
// -----------------------------------------------------------------------------
package mul_tree_feeder_pkg;

  typedef enum logic [1:0] {
    TWO_IN   = 2'd0,
    THREE_IN = 2'd1,
    FOUR_IN  = 2'd2,
    SIX_IN   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_FILL       = 1'b0,
    ST_WAIT_DRAIN = 1'b1
  } feed_state_e;

  localparam logic [31:0] ONE_FP       = 32'h3F80_0000;
  localparam int          LATENCY_DFLT = 9;
  localparam int          NUM_WORDS    = 8;

  function automatic logic [3:0] batch_len(input mode_e m);
    return ((m == THREE_IN) || (m == SIX_IN)) ? 4'd6 : 4'd8;
  endfunction

  // 3-input nodes occupy words 0-2 and 4-6; words 3 and 7 stay padding.
  function automatic logic [2:0] slot_of(input mode_e m, input logic [2:0] k);
    if ((m == THREE_IN) && (k >= 3'd3)) begin
      return k + 3'd1;
    end
    return k;
  endfunction

  // ceil(filled / arity); a 6-input batch is always a single node.
  function automatic logic [2:0] nodes_of(input mode_e m, input logic [3:0] filled);
    logic [2:0] n;
    case (m)
      TWO_IN:   n = filled[3:1] + {2'b00, filled[0]};
      THREE_IN: n = (filled > 4'd3) ? 3'd2 : 3'd1;
      FOUR_IN:  n = (filled > 4'd4) ? 3'd2 : 3'd1;
      default:  n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mul_tree_feeder_if.sv
// -----------------------------------------------------------------------------
// mul_tree_feeder_if
// Word-serial child stream in, packed operand bus out.
//  in_data/in_valid/in_ready : FP32 child stream with valid/ready handshake
//  in_mode                   : arity mode, sampled on the first word of a batch
//  in_flush                  : issue the current partial batch
//  mul_ins/mul_stb           : 256-bit operand bus and one-cycle issue strobe
//  mode                      : arity mode presented to the tree
//  issue_nodes               : populated node count, valid with mul_stb
//  busy                      : batch partially filled or products in flight
// master = stream source / tree side, slave = feeder.
// -----------------------------------------------------------------------------
interface mul_tree_feeder_if
  import mul_tree_feeder_pkg::*;
;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  mode_e        in_mode;
  logic         in_flush;
  logic [255:0] mul_ins;
  logic         mul_stb;
  mode_e        mode;
  logic [2:0]   issue_nodes;
  logic         busy;

  modport master (
    output in_data, in_valid, in_mode, in_flush,
    input  in_ready, mul_ins, mul_stb, mode, issue_nodes, busy
  );

  modport slave (
    input  in_data, in_valid, in_mode, in_flush,
    output in_ready, mul_ins, mul_stb, mode, issue_nodes, busy
  );

endinterface

// File: rtl/mul_slot_map.sv
// -----------------------------------------------------------------------------
// mul_slot_map
// Combinational map from (mode, word index k) to the operand-bus slot.
//  i_mode : arity mode of the batch being filled
//  i_k    : index of the word about to be accepted
//  o_slot : destination word slot on the 256-bit bus
//  o_len  : batch length for the mode
//  o_last : word k completes the batch
// -----------------------------------------------------------------------------
module mul_slot_map
  import mul_tree_feeder_pkg::*;
(
  input  mode_e      i_mode,
  input  logic [2:0] i_k,
  output logic [2:0] o_slot,
  output logic [3:0] o_len,
  output logic       o_last
);

  assign o_slot = slot_of(i_mode, i_k);
  assign o_len  = batch_len(i_mode);
  assign o_last = ({1'b0, i_k} == (o_len - 4'd1));

endmodule

// File: rtl/mul_tree_feeder.sv
// -----------------------------------------------------------------------------
// mul_tree_feeder
// Packs a word-serial FP32 child stream into the multiply tree's operand bus
// and issues a one-cycle strobe per batch. The tree's arity mode only changes
// once all products of the previous mode have drained out of the pipeline.
//  clk  : clock
//  rst  : synchronous active-high reset (drops any partial batch)
//  bus  : mul_tree_feeder_if.slave (stream in, operand bus / status out)
// -----------------------------------------------------------------------------
module mul_tree_feeder
  import mul_tree_feeder_pkg::*;
#(
  parameter int LATENCY = LATENCY_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  mul_tree_feeder_if.slave bus
);

  localparam int DW = $clog2(LATENCY + 1);

  feed_state_e  r_state;
  feed_state_e  w_state_next;
  logic [2:0]   r_k;
  mode_e        r_mode;
  logic [DW-1:0] r_drain;
  logic [31:0]  r_staging [NUM_WORDS];
  logic [255:0] r_mul_ins;
  logic         r_mul_stb;
  logic [2:0]   r_issue_nodes;

  mode_e        w_eff_mode;
  logic [2:0]   w_slot;
  logic [3:0]   w_len;
  logic         w_last;
  logic         w_guard;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_issue;
  logic [3:0]   w_filled;
  logic [31:0]  w_word_next [NUM_WORDS];
  logic [255:0] w_bus_next;

  // A batch takes its mode from the first word; later words follow the latch.
  assign w_eff_mode = (r_k == 3'd0) ? bus.in_mode : r_mode;

  mul_slot_map u_slot_map (
    .i_mode (w_eff_mode),
    .i_k    (r_k),
    .o_slot (w_slot),
    .o_len  (w_len),
    .o_last (w_last)
  );

  // Hold off a first word that would change mode while products are in flight.
  assign w_guard = (r_k == 3'd0) && bus.in_valid &&
                   (bus.in_mode != r_mode) && (r_drain != '0);

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b1;
    case (r_state)
      ST_FILL: begin
        if (w_guard) begin
          w_in_ready   = 1'b0;
          w_state_next = ST_WAIT_DRAIN;
        end
      end
      ST_WAIT_DRAIN: begin
        w_in_ready = !w_guard;
        if (r_drain == '0) begin
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;
  // A flush on an empty batch only issues if it carries an accepted word.
  assign w_issue  = (w_accept && w_last) ||
                    (bus.in_flush && ((r_k != 3'd0) || w_accept));
  assign w_filled = (w_accept && w_last) ? w_len
                                         : ({1'b0, r_k} + {3'b000, w_accept});

  // Staging image including the word accepted this cycle, so an issue
  // captures the final word without an extra cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign w_word_next[gi] = (w_accept && (w_slot == 3'(gi))) ? bus.in_data
                                                                : r_staging[gi];
      assign w_bus_next[32*gi +: 32] = w_word_next[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k           <= 3'd0;
      r_mode        <= TWO_IN;
      r_drain       <= '0;
      r_mul_ins     <= '0;
      r_mul_stb     <= 1'b0;
      r_issue_nodes <= 3'd0;
    end else begin
      r_mul_stb <= w_issue;
      if (w_accept && (r_k == 3'd0)) begin
        r_mode <= bus.in_mode;
      end
      if (w_issue) begin
        r_k           <= 3'd0;
        r_drain       <= DW'(LATENCY);
        r_mul_ins     <= w_bus_next;
        r_issue_nodes <= nodes_of(w_eff_mode, w_filled);
      end else begin
        if (w_accept) begin
          r_k <= r_k + 3'd1;
        end
        if (r_drain != '0) begin
          r_drain <= r_drain - DW'(1);
        end
      end
    end
  end

  // Unused and partially filled slots read as 1.0 so they do not disturb products.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      r_staging[i] <= (rst || w_issue) ? ONE_FP : w_word_next[i];
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.mul_ins     = r_mul_ins;
  assign bus.mul_stb     = r_mul_stb;
  assign bus.mode        = r_mode;
  assign bus.issue_nodes = r_issue_nodes;
  assign bus.busy        = (r_k != 3'd0) || (r_drain != '0);

endmodule

// File: tb/tb_mul_tree_feeder.sv
// -----------------------------------------------------------------------------
// tb_mul_tree_feeder
// Drives batches through mul_tree_feeder; every batch pushes its expected
// operand bus, node count and strobe cycle to a scoreboard that is popped on
// each mul_stb.
// -----------------------------------------------------------------------------
module tb_mul_tree_feeder;
  import mul_tree_feeder_pkg::*;

  typedef struct {
    logic [255:0] ins;
    logic [2:0]   nodes;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_stb = 0;
  exp_t exp_q[$];
  int   exp_cyc_q[$];
  int   stb_log[$];

  mul_tree_feeder_if bus ();

  mul_tree_feeder #(.LATENCY(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fpv(input int idx);
    case (idx)
      1: return 32'h3F80_0000;
      2: return 32'h4000_0000;
      3: return 32'h4040_0000;
      4: return 32'h4080_0000;
      5: return 32'h40A0_0000;
      6: return 32'h40C0_0000;
      7: return 32'h40E0_0000;
      8: return 32'h4100_0000;
      default: return 32'h4110_0000 + (32'(idx - 9) << 20);
    endcase
  endfunction

  function automatic logic [2:0] exp_nodes(input mode_e m, input int n);
    case (m)
      TWO_IN:   return 3'((n + 1) / 2);
      THREE_IN: return 3'((n + 2) / 3);
      FOUR_IN:  return 3'((n + 3) / 4);
      default:  return 3'd1;
    endcase
  endfunction

  // Scoreboard consumer: one line per issued batch.
  initial begin
    exp_t e;
    int   ec;
    forever begin
      @(negedge clk);
      if (!rst && bus.mul_stb) begin
        n_stb++;
        stb_log.push_back(cyc);
        $display("strobe %0d cycle=%0d nodes=%0d mode=%0d ins=%h",
                 n_stb, cyc, bus.issue_nodes, bus.mode, bus.mul_ins);
        if (exp_q.size() == 0 || exp_cyc_q.size() == 0) begin
          check_eq("sb_underflow", 256'(exp_q.size()), 256'd1);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_eq("stb_ins", bus.mul_ins, e.ins);
          check_eq("stb_nodes", 256'(bus.issue_nodes), 256'(e.nodes));
          check_eq("stb_cycle", 256'(cyc), 256'(ec));
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input mode_e m, input logic fl,
                           output int stalls, output int acc_cyc, output mode_e stall_mode);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_flush = fl;
    stalls       = 0;
    acc_cyc      = 0;
    stall_mode   = bus.mode;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc + 1;
        break;
      end
      stalls++;
      stall_mode = bus.mode;
      if (stalls > 40) begin
        check_eq("ready_timeout", 256'(stalls), 256'd0);
        acc_cyc = cyc + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_flush = 1'b0;
  endtask

  // fl: 0 = no flush, 1 = flush with last word, 2 = separate flush cycle.
  task automatic send_batch(input mode_e m, input int n, input int base, input int fl,
                            input bit keep, output int stalls_tot, output mode_e first_stall_mode);
    exp_t  e;
    int    st;
    int    ac;
    int    slot;
    mode_e sm;
    e.ins = {8{ONE_FP}};
    for (int i = 0; i < n; i++) begin
      slot = (m == THREE_IN && i >= 3) ? i + 1 : i;
      e.ins[32*slot +: 32] = fpv(base + i);
    end
    e.nodes = exp_nodes(m, n);
    exp_q.push_back(e);
    $display("batch mode=%0d words=%0d flush=%0d", m, n, fl);
    stalls_tot       = 0;
    first_stall_mode = bus.mode;
    ac               = 0;
    for (int i = 0; i < n; i++) begin
      send_word(fpv(base + i), m, (fl == 1 && i == n - 1), st, ac, sm);
      stalls_tot += st;
      if (i == 0) first_stall_mode = sm;
    end
    if (fl == 2) begin
      bus.in_valid = 1'b0;
      bus.in_flush = 1'b1;
      @(negedge clk);
      ac = cyc + 1;
      @(posedge clk);
      #1;
      bus.in_flush = 1'b0;
    end
    exp_cyc_q.push_back(ac);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_eq("idle", 256'(bus.busy), 256'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    st;
    int    ac;
    int    stb_before;
    int    gap;
    mode_e sm;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_mode  = TWO_IN;
    bus.in_flush = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mul_ins", bus.mul_ins, 256'd0);
    check_eq("rst_mul_stb", 256'(bus.mul_stb), 256'd0);
    check_eq("rst_mode", 256'(bus.mode), 256'(TWO_IN));
    check_eq("rst_nodes", 256'(bus.issue_nodes), 256'd0);
    check_eq("rst_busy", 256'(bus.busy), 256'd0);
    check_eq("rst_in_ready", 256'(bus.in_ready), 256'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // mode0 full batch, 1.0..8.0
    send_batch(TWO_IN, 8, 1, 0, 1'b0, st, sm);
    check_eq("m0_stalls", 256'(st), 256'd0);
    @(negedge clk);
    check_eq("m0_busy", 256'(bus.busy), 256'd1);
    @(negedge clk);
    check_eq("stb_one_cycle", 256'(bus.mul_stb), 256'd0);
    @(posedge clk);
    #1;
    wait_idle();

    // mode1 full batch, 2.0..7.0
    send_batch(THREE_IN, 6, 2, 0, 1'b0, st, sm);
    wait_idle();

    // mode3, three words then a separate flush cycle
    send_batch(SIX_IN, 3, 3, 2, 1'b0, st, sm);
    wait_idle();

    // flush on an empty batch does nothing
    bus.in_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_flush = 1'b0;
    @(negedge clk);
    check_eq("flush_noop_stb", 256'(bus.mul_stb), 256'd0);
    check_eq("flush_noop_busy", 256'(bus.busy), 256'd0);
    @(posedge clk);
    #1;

    // mode2, five words with flush on the last
    send_batch(FOUR_IN, 5, 10, 1, 1'b0, st, sm);
    wait_idle();

    // mode0 batch, then mode2 offered in the issue cycle, then two
    // back-to-back mode2 batches with in_valid held high
    send_batch(TWO_IN, 8, 1, 0, 1'b0, st, sm);
    stb_before = n_stb;
    send_batch(FOUR_IN, 8, 11, 0, 1'b1, st, sm);
    check_eq("guard_stalls", 256'(st), 256'd9);
    check_eq("guard_mode_hold", 256'(sm), 256'(TWO_IN));
    check_eq("guard_mode_new", 256'(bus.mode), 256'(FOUR_IN));
    send_batch(FOUR_IN, 8, 19, 0, 1'b0, st, sm);
    check_eq("b2b_stalls", 256'(st), 256'd0);
    @(negedge clk);
    #1;
    check_eq("b2b_strobes", 256'(n_stb - stb_before), 256'd3);
    gap = (stb_log.size() >= 2) ? stb_log[stb_log.size()-1] - stb_log[stb_log.size()-2] : 0;
    check_eq("b2b_gap", 256'(gap), 256'd8);
    @(posedge clk);
    #1;
    wait_idle();

    // reset after 5 of 8 words, then a fresh batch
    for (int i = 0; i < 5; i++) begin
      send_word(fpv(40 + i), FOUR_IN, 1'b0, st, ac, sm);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    stb_before = n_stb;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_ins", bus.mul_ins, 256'd0);
    check_eq("midrst_busy", 256'(bus.busy), 256'd0);
    check_eq("midrst_mode", 256'(bus.mode), 256'(TWO_IN));
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_batch(TWO_IN, 8, 30, 0, 1'b0, st, sm);
    repeat (12) @(negedge clk);
    #1;
    check_eq("midrst_strobes", 256'(n_stb - stb_before), 256'd1);
    check_eq("sb_empty", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
